stepdir_decoder_corexy: RTL and testbench
=========================================

Name: stepdir_decoder_corexy

Overview:
Receive-side counterpart of the CoreXY step generator. It decodes two external step/dir/enable pulse streams (motor A = 1, motor B = 2) into signed motor positions and recovers Cartesian X/Y with remainder flags. It also measures the step period and reports motion status per motor. It sits between the driver-side pins (loopback or a monitored external controller) and the HPS register bridge, for position verification and closed-loop checks.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (min 2)
MIN_HIGH, 2, consecutive synchronized-high clocks required to accept a step (glitch filter, min 1)
TIMEOUT, 50000000, clocks without an accepted step before moving_x drops

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
step_in_1  in  1  motor 1 step, asynchronous
dir_in_1  in  1  motor 1 direction, 0 = +, 1 = -
enable_n_1  in  1  motor 1 driver enable, active low
step_in_2  in  1  motor 2 step, asynchronous
dir_in_2  in  1  motor 2 direction
enable_n_2  in  1  motor 2 driver enable, active low
clear  in  1  synchronous zero of both positions
position_1  out  32  motor 1 signed position, two's complement
position_2  out  32  motor 2 signed position
pos_x  out  32  (position_1 + position_2) >> 1, arithmetic
pos_y  out  32  (position_1 - position_2) >> 1, arithmetic
correction_x  out  1  LSB discarded from the X sum
correction_y  out  1  LSB discarded from the Y difference
period_1  out  32  clocks between the last two accepted motor 1 steps
period_2  out  32  same for motor 2
moving_1  out  1  motor 1 accepted a step within TIMEOUT clocks
moving_2  out  1  same for motor 2
steps_active  out  1  moving_1 | moving_2

Behaviour:
- Reset (reset_n = 0 at a clk edge): all outputs, synchronizers, filters and counters go to 0. Reset mid-pulse discards any partial pulse. A step already high when reset is released is not accepted until it has gone low and high again.
- step, dir and enable_n each pass through a SYNC_STAGES flop chain. All further logic uses the synchronized values only.
- Filter, per motor:
  - A high-run counter increments while synced step = 1 and clears when synced step = 0.
  - A step is accepted on the cycle the counter reaches MIN_HIGH, once per high phase. It re-arms only after a synced low.
  - Accept requires synced enable_n = 0. Otherwise the pulse is ignored, and the period and timeout counters are not touched.
- Latency: the input rising edge is accepted SYNC_STAGES + MIN_HIGH - 1 cycles later. position_x updates the cycle after accept. pos_x, pos_y and correction_* update one further cycle later.
- Count: on accept, synced dir = 0 increments and dir = 1 decrements. Arithmetic is 32-bit two's complement with silent wrap (0x7FFFFFFF + 1 = 0x80000000).
- Clear: positions become 0 on the next cycle. A step accepted in the same cycle as clear is dropped; clear wins. Clear does not affect period_x or moving_x.
- Both motors may be accepted in the same cycle. Each is counted independently.
- CoreXY recovery is registered:
  - sum = sext33(position_1) + sext33(position_2); diff = sext33(position_1) - sext33(position_2).
  - pos_x = sum[32:1], correction_x = sum[0].
  - pos_y = diff[32:1], correction_y = diff[0].
  - No overflow is possible because the arithmetic is 33-bit.
- Period, per motor:
  - A free counter increments each clock and saturates at 0xFFFFFFFF.
  - On accept: period_x = counter + 1, saturating, and counter = 0.
  - The first accepted step after reset loads the count since reset; software ignores it.
  - period_x holds its value otherwise.
- Motion: moving_x = 1 on accept. It falls on the cycle the counter equals TIMEOUT, and stays 0 until the next accept.
- No state machine beyond the filter arm/disarm bit (ARMED, WAIT_LOW) per motor.

Test Plan:
- Reset: hold reset_n = 0 for 5 clks while step_in_1 toggles -> every output 0. Release with step_in_1 = 1 -> no count until a low-high cycle.
- 10 pulses on motor 1, dir 0, 4 clks high / 4 clks low, defaults -> position_1 = 10, pos_x = 5, pos_y = 5, corrections 0. The first position_1 change occurs exactly 3 + 1 cycles after the first input edge.
- Glitch: a 1-clk high pulse with MIN_HIGH = 2 -> position unchanged. The same test with enable_n_1 = 1 and a 4-clk pulse -> unchanged.
- Mixed sign: 3 steps on motor 1 (dir 0) and 5 steps on motor 2 (dir 1) -> position_2 = 0xFFFFFFFB, pos_x = 0xFFFFFFFF, correction_x = 0, pos_y = 4, correction_y = 0. Then clear and apply 3 steps on motor 1 only -> pos_x = 1, correction_x = 1, pos_y = 1, correction_y = 1.
- Timing: TIMEOUT = 1000 with steps every 100 clks -> period_1 = 100 and moving_1 = 1. Stop stepping -> moving_1 falls exactly 1000 clks after the last accept, and period_1 stays 100.
- Boundaries: clear asserted on the same cycle as an accept -> position_1 = 0. Simultaneous accepts on both motors -> both counted. Preload position_1 to 0x7FFFFFFF via steps (or force) and apply +1 -> 0x80000000, with pos_x correct as the 33-bit result.

Source files
------------

// File: rtl/stepdir_decoder_corexy.sv
// Decodes two step/dir/enable streams into signed motor positions, recovers CoreXY X/Y,
// and measures step period and motion status per motor.
module stepdir_decoder_corexy #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2,
  parameter int TIMEOUT     = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step_in_1,
  input  logic        dir_in_1,
  input  logic        enable_n_1,
  input  logic        step_in_2,
  input  logic        dir_in_2,
  input  logic        enable_n_2,
  input  logic        clear,
  output logic [31:0] position_1,
  output logic [31:0] position_2,
  output logic [31:0] pos_x,
  output logic [31:0] pos_y,
  output logic        correction_x,
  output logic        correction_y,
  output logic [31:0] period_1,
  output logic [31:0] period_2,
  output logic        moving_1,
  output logic        moving_2,
  output logic        steps_active
);

  localparam int             HW           = $clog2(MIN_HIGH + 1);
  localparam logic [HW-1:0]  HIGH_MAX     = HW'(MIN_HIGH);
  localparam logic [HW-1:0]  HIGH_LAST    = HW'(MIN_HIGH - 1);
  localparam logic [31:0]    TIMEOUT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic {WAIT_LOW = 1'b0, ARMED = 1'b1} filt_t;

  logic [1:0]             step_raw, dir_raw, en_n_raw;
  logic [SYNC_STAGES-1:0] step_sync [2];
  logic [SYNC_STAGES-1:0] dir_sync  [2];
  logic [SYNC_STAGES-1:0] en_n_sync [2];
  logic [SYNC_STAGES-1:0] primed;
  logic [1:0]             step_s, dir_s, en_n_s;

  filt_t                  state    [2];
  logic [HW-1:0]          high_cnt [2];
  logic [1:0]             accept;

  logic [31:0]            free_cnt [2];
  logic [31:0]            period   [2];
  logic [1:0]             moving;

  logic [32:0]            sum_c, diff_c;

  assign step_raw = {step_in_2, step_in_1};
  assign dir_raw  = {dir_in_2, dir_in_1};
  assign en_n_raw = {enable_n_2, enable_n_1};

  // primed fills with ones as the synchronizers refill with real samples after reset,
  // so a step already high at release is never mistaken for a fresh low-high edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      primed <= '0;
      for (int i = 0; i < 2; i++) begin
        step_sync[i] <= '0;
        dir_sync[i]  <= '0;
        en_n_sync[i] <= '0;
      end
    end else begin
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        step_sync[i] <= {step_sync[i][SYNC_STAGES-2:0], step_raw[i]};
        dir_sync[i]  <= {dir_sync[i][SYNC_STAGES-2:0], dir_raw[i]};
        en_n_sync[i] <= {en_n_sync[i][SYNC_STAGES-2:0], en_n_raw[i]};
      end
    end
  end

  always_comb begin
    step_s = '0;
    dir_s  = '0;
    en_n_s = '0;
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      step_s[i] = step_sync[i][SYNC_STAGES-1];
      dir_s[i]  = dir_sync[i][SYNC_STAGES-1];
      en_n_s[i] = en_n_sync[i][SYNC_STAGES-1];
      accept[i] = step_s[i] && (state[i] == ARMED) && (high_cnt[i] == HIGH_LAST) && !en_n_s[i];
    end
  end

  // The pulse is consumed (disarmed) when the high run completes even if the driver
  // is disabled, so a disabled pulse cannot be counted later in the same high phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        state[i]    <= WAIT_LOW;
        high_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!step_s[i]) begin
          high_cnt[i] <= '0;
          if (primed[SYNC_STAGES-1]) state[i] <= ARMED;
        end else begin
          if (high_cnt[i] != HIGH_MAX) high_cnt[i] <= high_cnt[i] + HW'(1);
          if (high_cnt[i] == HIGH_LAST) state[i] <= WAIT_LOW;
        end
      end
    end
  end

  function automatic logic [31:0] step_delta(input logic dir);
    return dir ? 32'hFFFF_FFFF : 32'h0000_0001;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      position_1 <= '0;
      position_2 <= '0;
    end else if (clear) begin
      position_1 <= '0;
      position_2 <= '0;
    end else begin
      if (accept[0]) position_1 <= position_1 + step_delta(dir_s[0]);
      if (accept[1]) position_2 <= position_2 + step_delta(dir_s[1]);
    end
  end

  always_comb begin
    sum_c  = {position_1[31], position_1} + {position_2[31], position_2};
    diff_c = {position_1[31], position_1} - {position_2[31], position_2};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_x        <= '0;
      pos_y        <= '0;
      correction_x <= 1'b0;
      correction_y <= 1'b0;
    end else begin
      pos_x        <= sum_c[32:1];
      pos_y        <= diff_c[32:1];
      correction_x <= sum_c[0];
      correction_y <= diff_c[0];
    end
  end

  // moving drops on the same edge the free counter reaches TIMEOUT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        free_cnt[i] <= '0;
        period[i]   <= '0;
      end
      moving <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          period[i]   <= (free_cnt[i] == 32'hFFFF_FFFF) ? free_cnt[i] : free_cnt[i] + 32'd1;
          free_cnt[i] <= '0;
          moving[i]   <= 1'b1;
        end else begin
          if (free_cnt[i] != 32'hFFFF_FFFF) free_cnt[i] <= free_cnt[i] + 32'd1;
          if (free_cnt[i] == TIMEOUT_LAST) moving[i] <= 1'b0;
        end
      end
    end
  end

  assign period_1     = period[0];
  assign period_2     = period[1];
  assign moving_1     = moving[0];
  assign moving_2     = moving[1];
  assign steps_active = moving[0] | moving[1];

endmodule

// File: tb/tb_stepdir_decoder_corexy.sv
// Scoreboard bench for stepdir_decoder_corexy: directed pulse trains with hand-computed
// expectations queued by the stimulus and checked by an independent monitor.
module tb_stepdir_decoder_corexy;

  logic        clk = 1'b0;
  logic        reset_n, clear;
  logic        step_in_1, dir_in_1, enable_n_1;
  logic        step_in_2, dir_in_2, enable_n_2;
  logic [31:0] position_1, position_2, pos_x, pos_y, period_1, period_2;
  logic        correction_x, correction_y, moving_1, moving_2, steps_active;

  always #5 clk = ~clk;

  stepdir_decoder_corexy #(.SYNC_STAGES(2), .MIN_HIGH(2), .TIMEOUT(1000)) dut (
    .clk(clk), .reset_n(reset_n),
    .step_in_1(step_in_1), .dir_in_1(dir_in_1), .enable_n_1(enable_n_1),
    .step_in_2(step_in_2), .dir_in_2(dir_in_2), .enable_n_2(enable_n_2),
    .clear(clear),
    .position_1(position_1), .position_2(position_2),
    .pos_x(pos_x), .pos_y(pos_y),
    .correction_x(correction_x), .correction_y(correction_y),
    .period_1(period_1), .period_2(period_2),
    .moving_1(moving_1), .moving_2(moving_2), .steps_active(steps_active)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   meas_lat, meas_dur, n;
  logic mov_at_accept;

  localparam int S_P1 = 0, S_P2 = 1, S_PX = 2, S_PY = 3, S_CX = 4, S_CY = 5, S_PER1 = 6,
                 S_PER2 = 7, S_MOV1 = 8, S_MOV2 = 9, S_ACT = 10, S_LAT = 11, S_DUR = 12,
                 S_MOVACC = 13;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_P1:     return position_1;
      S_P2:     return position_2;
      S_PX:     return pos_x;
      S_PY:     return pos_y;
      S_CX:     return {31'b0, correction_x};
      S_CY:     return {31'b0, correction_y};
      S_PER1:   return period_1;
      S_PER2:   return period_2;
      S_MOV1:   return {31'b0, moving_1};
      S_MOV2:   return {31'b0, moving_2};
      S_ACT:    return {31'b0, steps_active};
      S_LAT:    return 32'(meas_lat);
      S_DUR:    return 32'(meas_dur);
      S_MOVACC: return {31'b0, mov_at_accept};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drains every queued expectation against the settled outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.sel);
      total++;
      if (a !== e.exp) begin
        bad++;
        $display("[TB] FAIL %s: got 0x%08h want 0x%08h", e.name, a, e.exp);
      end
    end
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard drain %s: got %0d pending want 0", name, sb.size());
    end
  endtask

  // One pulse on the motors in mask, driven from a negedge.
  task automatic applyStimulus(input logic [1:0] mask, input logic d1, input logic d2,
                               input int hi, input int lo);
    if (mask[0]) begin dir_in_1 = d1; step_in_1 = 1'b1; end
    if (mask[1]) begin dir_in_2 = d2; step_in_2 = 1'b1; end
    tick(hi);
    if (mask[0]) step_in_1 = 1'b0;
    if (mask[1]) step_in_2 = 1'b0;
    tick(lo);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0;
    step_in_1 = 1'b0; dir_in_1 = 1'b0; enable_n_1 = 1'b0;
    step_in_2 = 1'b0; dir_in_2 = 1'b0; enable_n_2 = 1'b0;

    // Reset held while step toggles.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step_in_1 = ~step_in_1;
      tick(1);
    end
    checkOutput("reset position_1", S_P1, 32'd0);
    checkOutput("reset position_2", S_P2, 32'd0);
    checkOutput("reset pos_x", S_PX, 32'd0);
    checkOutput("reset pos_y", S_PY, 32'd0);
    checkOutput("reset correction_x", S_CX, 32'd0);
    checkOutput("reset correction_y", S_CY, 32'd0);
    checkOutput("reset period_1", S_PER1, 32'd0);
    checkOutput("reset period_2", S_PER2, 32'd0);
    checkOutput("reset moving_1", S_MOV1, 32'd0);
    checkOutput("reset moving_2", S_MOV2, 32'd0);
    checkOutput("reset steps_active", S_ACT, 32'd0);

    // Release with step already high: no count until a low-high cycle.
    step_in_1 = 1'b1;
    reset_n   = 1'b1;
    tick(10);
    checkOutput("high at release ignored", S_P1, 32'd0);
    step_in_1 = 1'b0;
    tick(4);
    applyStimulus(2'b01, 1'b0, 1'b0, 4, 4);
    checkOutput("rearm after low", S_P1, 32'd1);
    clear = 1'b1; tick(1); clear = 1'b0; tick(3);
    checkOutput("clear position_1", S_P1, 32'd0);

    // Ten pulses, first one timed from the input edge.
    dir_in_1 = 1'b0; step_in_1 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (position_1 == 32'd0 && n < 20);
    meas_lat = n;
    @(negedge clk);
    step_in_1 = 1'b0;
    tick(4);
    checkOutput("first step latency", S_LAT, 32'd4);
    for (int i = 0; i < 9; i++) applyStimulus(2'b01, 1'b0, 1'b0, 4, 4);
    tick(4);
    checkOutput("ten pulses position_1", S_P1, 32'd10);
    checkOutput("ten pulses pos_x", S_PX, 32'd5);
    checkOutput("ten pulses pos_y", S_PY, 32'd5);
    checkOutput("ten pulses correction_x", S_CX, 32'd0);
    checkOutput("ten pulses correction_y", S_CY, 32'd0);

    // Glitch rejection and disabled driver.
    applyStimulus(2'b01, 1'b0, 1'b0, 1, 6);
    checkOutput("glitch ignored", S_P1, 32'd10);
    enable_n_1 = 1'b1; tick(4);
    applyStimulus(2'b01, 1'b0, 1'b0, 4, 4);
    checkOutput("disabled ignored", S_P1, 32'd10);
    enable_n_1 = 1'b0; tick(4);

    // Mixed sign.
    clear = 1'b1; tick(1); clear = 1'b0; tick(2);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b0, 1'b0, 4, 4);
    for (int i = 0; i < 5; i++) applyStimulus(2'b10, 1'b0, 1'b1, 4, 4);
    tick(4);
    checkOutput("mixed position_1", S_P1, 32'd3);
    checkOutput("mixed position_2", S_P2, 32'hFFFF_FFFB);
    checkOutput("mixed pos_x", S_PX, 32'hFFFF_FFFF);
    checkOutput("mixed correction_x", S_CX, 32'd0);
    checkOutput("mixed pos_y", S_PY, 32'd4);
    checkOutput("mixed correction_y", S_CY, 32'd0);
    clear = 1'b1; tick(1); clear = 1'b0; tick(2);
    checkOutput("clear position_2", S_P2, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b0, 1'b0, 4, 4);
    tick(4);
    checkOutput("odd pos_x", S_PX, 32'd1);
    checkOutput("odd correction_x", S_CX, 32'd1);
    checkOutput("odd pos_y", S_PY, 32'd1);
    checkOutput("odd correction_y", S_CY, 32'd1);

    // Period and timeout: steps every 100 clocks, last one timed to the fall of moving_1.
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b0, 1'b0, 4, 96);
    step_in_1 = 1'b1;
    fork
      begin tick(4); step_in_1 = 1'b0; end
    join_none
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (position_1 == 32'd6 && n < 20);
    mov_at_accept = moving_1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (moving_1 && n < 1200);
    meas_dur = n;
    @(negedge clk);
    checkOutput("moving_1 after accept", S_MOVACC, 32'd1);
    checkOutput("moving_1 duration", S_DUR, 32'd1000);
    checkOutput("period_1", S_PER1, 32'd100);
    checkOutput("moving_1 after timeout", S_MOV1, 32'd0);
    checkOutput("steps_active idle", S_ACT, 32'd0);
    checkOutput("position_1 after timing", S_P1, 32'd7);

    // Clear on the accept cycle wins.
    dir_in_1 = 1'b0; step_in_1 = 1'b1;
    tick(3);
    clear = 1'b1; tick(1); clear = 1'b0;
    step_in_1 = 1'b0;
    tick(4);
    checkOutput("clear beats accept", S_P1, 32'd0);

    // Simultaneous accepts.
    applyStimulus(2'b11, 1'b0, 1'b0, 4, 4);
    tick(2);
    checkOutput("simultaneous position_1", S_P1, 32'd1);
    checkOutput("simultaneous position_2", S_P2, 32'd1);
    checkOutput("simultaneous pos_x", S_PX, 32'd1);
    checkOutput("simultaneous pos_y", S_PY, 32'd0);

    // Wrap at the positive limit; X/Y from the 33-bit sum and difference.
    force dut.position_1 = 32'h7FFF_FFFF;
    tick(1);
    release dut.position_1;
    tick(3);
    checkOutput("preload position_1", S_P1, 32'h7FFF_FFFF);
    checkOutput("preload pos_x", S_PX, 32'h4000_0000);
    checkOutput("preload correction_x", S_CX, 32'd0);
    checkOutput("preload pos_y", S_PY, 32'h3FFF_FFFF);
    applyStimulus(2'b01, 1'b0, 1'b0, 4, 4);
    tick(2);
    checkOutput("wrap position_1", S_P1, 32'h8000_0000);
    checkOutput("wrap pos_x", S_PX, 32'hC000_0000);
    checkOutput("wrap correction_x", S_CX, 32'd1);
    checkOutput("wrap pos_y", S_PY, 32'hBFFF_FFFF);
    checkOutput("wrap correction_y", S_CY, 32'd1);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
